// File: rtl/axil_weight_loader.sv
// axil_weight_loader: AXI4-Lite write master that streams a record table from a
// synchronous source RAM into the MLP config slave, one write per record.
module axil_weight_loader #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 5,
    parameter int SRC_ADDR_WIDTH     = 10,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_WEIGHT = 5'h00,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_BIAS   = 5'h04,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_LAYER  = 5'h10,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_NEURON = 5'h14
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [SRC_ADDR_WIDTH:0]         num_records,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic [SRC_ADDR_WIDTH:0]         records_sent,
    output logic                            src_rd_en,
    output logic [SRC_ADDR_WIDTH-1:0]       src_addr,
    input  logic [C_M_AXI_DATA_WIDTH+1:0]   src_data,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                      m_axi_awprot,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    input  logic [1:0]                      m_axi_bresp,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_WRITE,
        S_RESP,
        S_FIN
    } state_t;

    localparam logic [1:0]              BRESP_OKAY  = 2'b00;
    localparam logic [SRC_ADDR_WIDTH:0] MAX_RECORDS = {1'b1, {SRC_ADDR_WIDTH{1'b0}}};

    state_t                          state;
    state_t                          state_next;
    logic [SRC_ADDR_WIDTH:0]         num_latched;
    logic [SRC_ADDR_WIDTH:0]         num_clamped;
    logic [SRC_ADDR_WIDTH:0]         sent_inc;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   rec_addr;
    logic                            zero_start;
    logic                            aw_fire;
    logic                            w_fire;
    logic                            b_fire;
    logic                            aw_fin;
    logic                            w_fin;

    assign m_axi_awprot = '0;
    assign m_axi_wstrb  = '1;

    // Handshake qualifiers, record-count arithmetic and record-type address decode
    always_comb begin
        aw_fire     = m_axi_awvalid & m_axi_awready;
        w_fire      = m_axi_wvalid & m_axi_wready;
        b_fire      = (state == S_RESP) & m_axi_bvalid;
        // A channel is finished once its valid has dropped or it handshakes this cycle
        aw_fin      = ~m_axi_awvalid | aw_fire;
        w_fin       = ~m_axi_wvalid | w_fire;
        sent_inc    = records_sent + 1'b1;
        zero_start  = (state == S_IDLE) && start && (num_records == '0);
        num_clamped = (num_records > MAX_RECORDS) ? MAX_RECORDS : num_records;
        case (src_data[C_M_AXI_DATA_WIDTH+1:C_M_AXI_DATA_WIDTH])
            2'd0:    rec_addr = ADDR_LAYER;
            2'd1:    rec_addr = ADDR_NEURON;
            2'd2:    rec_addr = ADDR_WEIGHT;
            default: rec_addr = ADDR_BIAS;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the strobes that follow the state directly
    always_comb begin
        state_next   = state;
        src_rd_en    = 1'b0;
        m_axi_bready = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && (num_records != '0)) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                src_rd_en  = 1'b1;
                state_next = S_LATCH;
            end
            S_LATCH: begin
                state_next = S_WRITE;
            end
            S_WRITE: begin
                if (aw_fin && w_fin) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    if ((m_axi_bresp != BRESP_OKAY) || (sent_inc == num_latched)) begin
                        state_next = S_FIN;
                    end else begin
                        state_next = S_FETCH;
                    end
                end
            end
            S_FIN: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Load bookkeeping, status flags and the AW/W channel registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            records_sent  <= '0;
            src_addr      <= '0;
            num_latched   <= '0;
            m_axi_awaddr  <= '0;
            m_axi_wdata   <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
        end else begin
            // done is high during FIN, or one cycle after a zero-length start
            done <= zero_start || (state_next == S_FIN);
            case (state)
                S_IDLE: begin
                    if (start && (num_records != '0)) begin
                        busy         <= 1'b1;
                        err          <= 1'b0;
                        records_sent <= '0;
                        src_addr     <= '0;
                        num_latched  <= num_clamped;
                    end
                end
                S_LATCH: begin
                    m_axi_awaddr  <= rec_addr;
                    m_axi_wdata   <= src_data[C_M_AXI_DATA_WIDTH-1:0];
                    m_axi_awvalid <= 1'b1;
                    m_axi_wvalid  <= 1'b1;
                end
                S_WRITE: begin
                    if (aw_fire) begin
                        m_axi_awvalid <= 1'b0;
                    end
                    if (w_fire) begin
                        m_axi_wvalid <= 1'b0;
                    end
                end
                S_RESP: begin
                    if (b_fire) begin
                        records_sent <= sent_inc;
                        if (m_axi_bresp != BRESP_OKAY) begin
                            err <= 1'b1;
                        end
                        // src_addr only advances when another record follows, so it never wraps
                        if (state_next == S_FIN) begin
                            busy <= 1'b0;
                        end else begin
                            src_addr <= src_addr + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_weight_loader.sv
// tb_axil_weight_loader: directed bench with a source-RAM model, a configurable
// AXI-Lite slave and an expected-write list derived from the record table.
`timescale 1ns/1ps
module tb_axil_weight_loader;

    localparam int SAW = 10;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [SAW:0]   num_records;
    logic           busy, done, err;
    logic [SAW:0]   records_sent;
    logic           src_rd_en;
    logic [SAW-1:0] src_addr;
    logic [33:0]    src_data;
    logic [4:0]     awaddr;
    logic [2:0]     awprot;
    logic           awvalid, awready;
    logic [31:0]    wdata;
    logic [3:0]     wstrb;
    logic           wvalid, wready;
    logic [1:0]     bresp;
    logic           bvalid, bready;

    always #5 clk = ~clk;

    axil_weight_loader #(
        .C_M_AXI_DATA_WIDTH (32),
        .C_M_AXI_ADDR_WIDTH (5),
        .SRC_ADDR_WIDTH     (SAW),
        .ADDR_WEIGHT        (5'h00),
        .ADDR_BIAS          (5'h04),
        .ADDR_LAYER         (5'h10),
        .ADDR_NEURON        (5'h14)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .num_records   (num_records),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .records_sent  (records_sent),
        .src_rd_en     (src_rd_en),
        .src_addr      (src_addr),
        .src_data      (src_data),
        .m_axi_awaddr  (awaddr),
        .m_axi_awprot  (awprot),
        .m_axi_awvalid (awvalid),
        .m_axi_awready (awready),
        .m_axi_wdata   (wdata),
        .m_axi_wstrb   (wstrb),
        .m_axi_wvalid  (wvalid),
        .m_axi_wready  (wready),
        .m_axi_bresp   (bresp),
        .m_axi_bvalid  (bvalid),
        .m_axi_bready  (bready)
    );

    // Synchronous source RAM: data one cycle after the read strobe
    logic [33:0] mem [0:1023];
    always @(posedge clk) begin
        if (src_rd_en) src_data <= mem[src_addr];
    end

    // Slave behaviour knobs and expected write list
    int          aw_delay, w_delay, b_delay, err_rec;
    logic [4:0]  exp_addr [0:1023];
    logic [31:0] exp_data [0:1023];
    int          exp_n;
    logic [4:0]  obs_addr [0:3];
    logic [31:0] obs_data [0:3];

    int          aw_idx, w_idx, b_idx, fetch_idx, done_cnt;
    int          aw_cnt, w_cnt, b_wait;
    bit          aw_hold, w_hold;
    logic [4:0]  aw_hold_val;
    logic [31:0] w_hold_val;
    int          checks, errors;

    function automatic logic [4:0] map_addr(input logic [1:0] t);
        case (t)
            2'd0:    return 5'h10;
            2'd1:    return 5'h14;
            2'd2:    return 5'h00;
            default: return 5'h04;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        aw_idx = 0; w_idx = 0; b_idx = 0; fetch_idx = 0; done_cnt = 0;
        aw_cnt = 0; w_cnt = 0; b_wait = 0; aw_hold = 0; w_hold = 0;
    endtask

    // Slave model and per-cycle compare; everything decided at the falling edge
    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (rst) begin
                awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
                clear_counts();
            end else begin
                if (start && !busy) clear_counts();
                if (done) done_cnt++;
                if (src_rd_en) begin
                    chk("src_addr", src_addr, fetch_idx);
                    fetch_idx++;
                end
                // B channel: response only after both AW and W of this write completed
                if (aw_idx > b_idx && w_idx > b_idx) begin
                    bvalid = (b_wait >= b_delay);
                    b_wait++;
                    bresp  = (b_idx + 1 == err_rec) ? 2'b10 : 2'b00;
                    if (bvalid && bready) begin
                        b_idx++;
                        b_wait = 0;
                    end
                end else begin
                    bvalid = 1'b0;
                    b_wait = 0;
                end
                // AW channel
                if (awvalid) begin
                    if (aw_hold) chk("awaddr_stable", awaddr, aw_hold_val);
                    chk("aw_single_outstanding", aw_idx, b_idx);
                    awready = (aw_cnt >= aw_delay);
                    aw_cnt++;
                    if (awready) begin
                        chk("aw_count_limit", aw_idx < exp_n, 1);
                        if (aw_idx < exp_n) chk("awaddr", awaddr, exp_addr[aw_idx]);
                        chk("awprot", awprot, 0);
                        if (aw_idx < 4) obs_addr[aw_idx] = awaddr;
                        aw_idx++;
                        aw_cnt  = 0;
                        aw_hold = 0;
                    end else begin
                        aw_hold     = 1;
                        aw_hold_val = awaddr;
                    end
                end else begin
                    awready = 1'b0; aw_cnt = 0; aw_hold = 0;
                end
                // W channel
                if (wvalid) begin
                    if (w_hold) chk("wdata_stable", wdata, w_hold_val);
                    chk("w_single_outstanding", w_idx, b_idx);
                    wready = (w_cnt >= w_delay);
                    w_cnt++;
                    if (wready) begin
                        chk("w_count_limit", w_idx < exp_n, 1);
                        if (w_idx < exp_n) chk("wdata", wdata, exp_data[w_idx]);
                        chk("wstrb", wstrb, 4'hF);
                        if (w_idx < 4) obs_data[w_idx] = wdata;
                        w_idx++;
                        w_cnt  = 0;
                        w_hold = 0;
                    end else begin
                        w_hold     = 1;
                        w_hold_val = wdata;
                    end
                end else begin
                    wready = 1'b0; w_cnt = 0; w_hold = 0;
                end
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    task automatic setup_load(input int n, input int ad, input int wd, input int bd,
                              input int er, input int nw);
        aw_delay = ad; w_delay = wd; b_delay = bd; err_rec = er;
        exp_n = nw;
        for (int k = 0; k < nw; k++) begin
            exp_addr[k] = map_addr(mem[k][33:32]);
            exp_data[k] = mem[k][31:0];
        end
        num_records = n[SAW:0];
    endtask

    task automatic run_load(input int n, input int ad, input int wd, input int bd,
                            input int er, input int nw, input bit exp_err,
                            input string tag, input bit poke_start);
        bit seen;
        setup_load(n, ad, wd, bd, er, nw);
        pulse_start();
        seen = 0;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            if (poke_start && c == 5) begin
                start = 1'b1; num_records = 11'd7;
            end else if (poke_start && c == 6) begin
                start = 1'b0;
            end
            if (done) begin
                seen = 1;
                chk({tag, "_records_sent"}, records_sent, nw);
                chk({tag, "_err_at_done"}, err, exp_err);
                chk({tag, "_busy_at_done"}, busy, 0);
                break;
            end
        end
        chk({tag, "_done_seen"}, seen, 1);
        repeat (8) @(posedge clk);
        chk({tag, "_aw_writes"}, aw_idx, nw);
        chk({tag, "_w_writes"}, w_idx, nw);
        chk({tag, "_b_resps"}, b_idx, nw);
        chk({tag, "_fetches"}, fetch_idx, nw);
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_err_sticky"}, err, exp_err);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        checks = 0; errors = 0;
        rst = 1'b1; start = 1'b0; num_records = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        aw_delay = 0; w_delay = 0; b_delay = 0; err_rec = 0; exp_n = 0;
        clear_counts();
        for (int i = 0; i < 1024; i++) begin
            mem[i] = {2'(i * 7 >> 1), 32'(i * 32'h0101_0101 + 5)};
        end
        mem[0] = {2'd0, 32'h0000_0001};
        mem[1] = {2'd1, 32'h0000_0000};
        mem[2] = {2'd2, 32'h0000_0100};
        mem[3] = {2'd3, 32'hFFFF_FF80};
        fork
            monitor_loop();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_src_rd_en", src_rd_en, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_src_addr", src_addr, 0);
        chk("rst_awaddr", awaddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_records_sent", records_sent, 0);
        @(posedge clk); #2 rst = 1'b0;

        // Four-record table, zero-wait slave, literal pin of the map
        run_load(4, 0, 0, 0, 0, 4, 1'b0, "t1", 1'b0);
        chk("t1_addr0", obs_addr[0], 5'h10);
        chk("t1_addr1", obs_addr[1], 5'h14);
        chk("t1_addr2", obs_addr[2], 5'h00);
        chk("t1_addr3", obs_addr[3], 5'h04);
        chk("t1_data0", obs_data[0], 32'h0000_0001);
        chk("t1_data1", obs_data[1], 32'h0000_0000);
        chk("t1_data2", obs_data[2], 32'h0000_0100);
        chk("t1_data3", obs_data[3], 32'hFFFF_FF80);

        // Skewed handshakes in both orders, plus a delayed response
        run_load(4, 3, 0, 0, 0, 4, 1'b0, "t2_aw_late", 1'b0);
        run_load(4, 0, 3, 1, 0, 4, 1'b0, "t2_w_late", 1'b0);

        // Error response on record 2 of 5 aborts the load
        run_load(5, 0, 0, 0, 2, 2, 1'b1, "t3_err", 1'b0);

        // start while busy is ignored; err cleared by the new start
        run_load(3, 1, 2, 0, 0, 3, 1'b0, "t6_restart", 1'b1);

        // Zero-length load
        setup_load(0, 0, 0, 0, 0, 0);
        pulse_start();
        @(negedge clk);
        chk("t4_done", done, 1);
        chk("t4_busy", busy, 0);
        @(negedge clk);
        chk("t4_done_drop", done, 0);
        chk("t4_busy_idle", busy, 0);
        repeat (4) @(posedge clk);
        chk("t4_no_aw", aw_idx, 0);
        chk("t4_no_fetch", fetch_idx, 0);
        chk("t4_done_pulses", done_cnt, 1);

        // Asynchronous reset while a write is pending, then replay
        setup_load(3, 30, 0, 0, 0, 3);
        pulse_start();
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (awvalid) begin
                seen = 1;
                break;
            end
        end
        chk("t5_awvalid_seen", seen, 1);
        #1 rst = 1'b1;
        #1;
        chk("t5_awvalid_drop", awvalid, 0);
        chk("t5_wvalid_drop", wvalid, 0);
        chk("t5_bready_drop", bready, 0);
        chk("t5_busy_drop", busy, 0);
        chk("t5_rd_en_drop", src_rd_en, 0);
        chk("t5_sent_clear", records_sent, 0);
        @(negedge clk);
        @(posedge clk); #2 rst = 1'b0;
        run_load(3, 0, 0, 0, 0, 3, 1'b0, "t5_replay", 1'b0);

        // Oversized count clamps to the RAM depth
        run_load(2047, 0, 0, 0, 0, 1024, 1'b0, "t7_clamp", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
